// File: rtl/data_mem_responder_if.sv
// Data-port bus between Core (master) and the data-memory responder (slave).
// Request fields are held by the master until mem_ready is returned.
interface data_mem_responder_if;
    logic [31:0] mem_address;
    logic [31:0] mem_input;
    logic        mem_enable;
    logic        mem_r_w;
    logic [31:0] mem_output;
    logic        mem_ready;
    logic        mem_fault;
    logic        mem_busy;

    modport master (
        output mem_address, mem_input, mem_enable, mem_r_w,
        input  mem_output, mem_ready, mem_fault, mem_busy
    );

    modport slave (
        input  mem_address, mem_input, mem_enable, mem_r_w,
        output mem_output, mem_ready, mem_fault, mem_busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port: one request at a time, fixed
// LATENCY wait, one-cycle mem_ready pulse qualified by mem_fault.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_responder_if.slave bus
);
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic [IDX_W-1:0]   lat_idx;
    logic [31:0]        lat_data;
    logic               lat_rw;
    logic               lat_fault;

    logic               accept;
    logic               enter_resp;
    logic               in_fault;
    logic [IDX_W-1:0]   req_idx;
    logic [31:0]        req_data;
    logic               req_rw;
    logic               req_fault;

    logic [31:0]        mem [DEPTH_WORDS];

    // With LATENCY=0 the access happens on the acceptance edge itself, so the
    // request is taken straight from the bus instead of the latches.
    always_comb begin
        accept     = (state == IDLE) && bus.mem_enable;
        in_fault   = (bus.mem_address[1:0] != 2'b00) || (bus.mem_address >= ADDR_LIMIT);
        req_idx    = accept ? bus.mem_address[IDX_W+1:2] : lat_idx;
        req_data   = accept ? bus.mem_input : lat_data;
        req_rw     = accept ? bus.mem_r_w : lat_rw;
        req_fault  = accept ? in_fault : lat_fault;
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.mem_enable) begin
                    if (LATENCY > 0) begin
                        state_next = WAIT;
                        cnt_next   = 4'(LATENCY - 1);
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The array shares this process so a reset edge can never commit a write;
    // its contents are deliberately left out of the reset branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            lat_idx        <= '0;
            lat_data       <= '0;
            lat_rw         <= 1'b0;
            lat_fault      <= 1'b0;
            bus.mem_output <= '0;
            bus.mem_ready  <= 1'b0;
            bus.mem_fault  <= 1'b0;
            bus.mem_busy   <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            bus.mem_busy <= (state_next != IDLE);
            if (accept) begin
                lat_idx   <= req_idx;
                lat_data  <= req_data;
                lat_rw    <= req_rw;
                lat_fault <= req_fault;
            end
            if (enter_resp) begin
                bus.mem_ready  <= 1'b1;
                bus.mem_fault  <= req_fault;
                bus.mem_output <= (!req_rw && !req_fault) ? mem[req_idx] : '0;
                if (req_rw && !req_fault) begin
                    mem[req_idx] <= req_data;
                end
            end else begin
                bus.mem_ready  <= 1'b0;
                bus.mem_fault  <= 1'b0;
                bus.mem_output <= '0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, per-DUT monitors pop
// and compare on every mem_ready. Two instances: LATENCY=2 and LATENCY=0.
module tb_data_mem_responder;
    localparam int unsigned LAT2 = 2;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        logic        chk_data;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst2 = 1'b0;
    logic        rst0 = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q2[$];
    exp_t        q0[$];

    data_mem_responder_if bus2();
    data_mem_responder_if bus0();

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT2)) dut2 (
        .clk(clk), .reset(rst2), .bus(bus2)
    );
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready is expected in the cycle that starts LATENCY edges after the
    // acceptance edge (the 3rd edge counting acceptance as the 1st for LATENCY=2).
    always @(negedge clk) begin
        if (bus2.mem_ready !== 1'b0) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut2_unexpected_ready: got ready=%b expected none (cycle %0d)", bus2.mem_ready, cyc);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2_fault", 32'(bus2.mem_fault), 32'(e.fault));
                if (e.chk_data) chk("dut2_rdata", bus2.mem_output, e.data);
                chk("dut2_ready_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        if (bus0.mem_ready !== 1'b0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_ready: got ready=%b expected none (cycle %0d)", bus0.mem_ready, cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0_fault", 32'(bus0.mem_fault), 32'(e.fault));
                if (e.chk_data) chk("dut0_rdata", bus0.mem_output, e.data);
                chk("dut0_ready_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // One LATENCY=2 access; the request fields are scrambled right after
    // acceptance so only the latched copy can produce the expected result.
    task automatic req2(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_fault);
        exp_t e;
        int   n;
        @(negedge clk);
        bus2.mem_r_w     = rw;
        bus2.mem_address = addr;
        bus2.mem_input   = wdata;
        bus2.mem_enable  = 1'b1;
        @(posedge clk);
        #1;
        e.data = exp_data; e.fault = exp_fault; e.chk_data = ~rw; e.due = cyc + LAT2;
        q2.push_back(e);
        @(negedge clk);
        bus2.mem_address = addr ^ 32'h4;
        bus2.mem_input   = ~wdata;
        bus2.mem_r_w     = ~rw;
        n = 0;
        while (bus2.mem_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus2.mem_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL dut2_ready_timeout: got no ready expected ready for addr %h", addr);
        end
        bus2.mem_enable = 1'b0;
    endtask

    localparam logic        ZRW [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [31:0] ZA  [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h4};
    localparam logic [31:0] ZD  [6] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2,
                                        32'hD3D3D3D3, 32'h0, 32'h0};
    localparam logic [31:0] ZE  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hC2C2C2C2, 32'hD3D3D3D3};

    initial begin
        bus2.mem_address = '0; bus2.mem_input = '0; bus2.mem_enable = 1'b0; bus2.mem_r_w = 1'b0;
        bus0.mem_address = '0; bus0.mem_input = '0; bus0.mem_enable = 1'b0; bus0.mem_r_w = 1'b0;
        repeat (2) @(negedge clk);
        chk("dut2_rst_ready",  32'(bus2.mem_ready), 32'h0);
        chk("dut2_rst_fault",  32'(bus2.mem_fault), 32'h0);
        chk("dut2_rst_busy",   32'(bus2.mem_busy),  32'h0);
        chk("dut2_rst_output", bus2.mem_output,     32'h0);
        chk("dut0_rst_ready",  32'(bus0.mem_ready), 32'h0);
        chk("dut0_rst_fault",  32'(bus0.mem_fault), 32'h0);
        chk("dut0_rst_busy",   32'(bus0.mem_busy),  32'h0);
        chk("dut0_rst_output", bus0.mem_output,     32'h0);
        rst2 = 1'b1;
        rst0 = 1'b1;

        req2(1'b1, 32'h0000_0020, 32'h11112222, 32'h0, 1'b0);
        req2(1'b1, 32'h0000_0000, 32'h0BADF00D, 32'h0, 1'b0);
        req2(1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 1'b0);
        req2(1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0);
        req2(1'b1, 32'h0000_0011, 32'h12345678, 32'h0, 1'b1);
        req2(1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0);
        req2(1'b0, 32'h0000_1000, 32'h0,        32'h0, 1'b1);
        req2(1'b1, 32'h0000_0FFC, 32'hA5A5A5A5, 32'h0, 1'b0);
        req2(1'b0, 32'h0000_0FFC, 32'h0,        32'hA5A5A5A5, 1'b0);
        req2(1'b1, 32'h0000_1000, 32'h77777777, 32'h0, 1'b1);
        req2(1'b0, 32'h0000_0000, 32'h0,        32'h0BADF00D, 1'b0);
        req2(1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0, 1'b1);
        req2(1'b0, 32'h0000_0013, 32'h0,        32'h0, 1'b1);

        // Reset while the write to 0x20 is waiting: abandoned, no ready.
        @(negedge clk);
        bus2.mem_r_w = 1'b1; bus2.mem_address = 32'h20; bus2.mem_input = 32'hCAFEF00D;
        bus2.mem_enable = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        bus2.mem_enable = 1'b0;
        #1;
        chk("midrst_ready",  32'(bus2.mem_ready), 32'h0);
        chk("midrst_fault",  32'(bus2.mem_fault), 32'h0);
        chk("midrst_busy",   32'(bus2.mem_busy),  32'h0);
        chk("midrst_output", bus2.mem_output,     32'h0);
        @(negedge clk);
        rst2 = 1'b1;
        repeat (4) @(negedge clk);
        req2(1'b0, 32'h0000_0020, 32'h0, 32'h11112222, 1'b0);

        // LATENCY=0 with mem_enable held high: one access every 2 cycles.
        @(negedge clk);
        bus0.mem_r_w = ZRW[0]; bus0.mem_address = ZA[0]; bus0.mem_input = ZD[0];
        bus0.mem_enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            @(posedge clk);
            #1;
            e.data = ZE[k]; e.fault = 1'b0; e.chk_data = ~ZRW[k]; e.due = cyc;
            q0.push_back(e);
            @(negedge clk);
            chk("dut0_busy_resp", 32'(bus0.mem_busy), 32'h1);
            if (k < 5) begin
                bus0.mem_r_w = ZRW[k+1]; bus0.mem_address = ZA[k+1]; bus0.mem_input = ZD[k+1];
            end else begin
                bus0.mem_enable = 1'b0;
            end
            @(negedge clk);
            chk("dut0_busy_idle", 32'(bus0.mem_busy), 32'h0);
        end

        repeat (4) @(negedge clk);
        chk("dut2_queue_drained", 32'(q2.size()), 32'h0);
        chk("dut0_queue_drained", 32'(q0.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
